// File: rtl/pit_bus_controller_pkg.sv
// Shared encodings and types for the PIT host-bus controller and its per-counter sequencers.
// Read/write mode field values, control-word address, read-back selector and the sampled bus word.
package pit_pkg;

   typedef enum logic [1:0] {
      RW_LATCH = 2'b00,
      RW_LSB   = 2'b01,
      RW_MSB   = 2'b10,
      RW_BOTH  = 2'b11
   } rw_t;

   localparam logic [1:0] CW_ADDR     = 2'd3;
   localparam logic [1:0] SC_READBACK = 2'd3;

   typedef struct packed {
      logic       cs;
      logic       rd;
      logic       wr;
      logic [1:0] a;
      logic [7:0] d;
   } smp_t;

   // Strobes idle high so a reset never looks like an asserted strobe.
   localparam smp_t SMP_IDLE = '{cs: 1'b1, rd: 1'b1, wr: 1'b1, a: 2'd0, d: 8'd0};

endpackage

// File: rtl/pit_bus_controller_if.sv
// Host-side 8-bit microprocessor bus of the PIT: address, active-low strobes, split data bus.
// The host is the master; the controller is the slave and drives read data with its enable.
interface pit_bus_controller_if;
   logic [1:0] A;
   logic       CS;
   logic       RD;
   logic       WR;
   logic [7:0] D_in;
   logic [7:0] D_out;
   logic       D_oe;

   modport master (output A, CS, RD, WR, D_in, input D_out, D_oe);
   modport slave  (input A, CS, RD, WR, D_in, output D_out, D_oe);
endinterface

// File: rtl/pit_bus_controller_chan_seq.sv
// Per-counter access sequencer: mode, byte toggles, latch flags, read-byte select.
// Pulses are registered one cycle after a request; no backpressure, requests are single-cycle.
module pit_chan_seq
   import pit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cw_req,
   input  rw_t         cw_rw,
   input  logic        latch_cnt_req,
   input  logic        latch_sts_req,
   input  logic        wr_req,
   input  logic        rd_req,
   input  logic [15:0] ol,
   input  logic [7:0]  sts,
   output logic        cw_wr,
   output logic        cr_wr,
   output logic        cr_msb,
   output logic        latch_cnt,
   output logic        latch_sts,
   output logic [7:0]  rd_dat
);

   rw_t  rw;
   logic wr_toggle;
   logic rd_toggle;
   logic cnt_latched;
   logic sts_latched;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rw          <= RW_LATCH;
         wr_toggle   <= 1'b0;
         rd_toggle   <= 1'b0;
         cnt_latched <= 1'b0;
         sts_latched <= 1'b0;
         cw_wr       <= 1'b0;
         cr_wr       <= 1'b0;
         cr_msb      <= 1'b0;
         latch_cnt   <= 1'b0;
         latch_sts   <= 1'b0;
      end else begin
         cw_wr     <= 1'b0;
         cr_wr     <= 1'b0;
         cr_msb    <= 1'b0;
         latch_cnt <= 1'b0;
         latch_sts <= 1'b0;
         if (cw_req) begin
            rw          <= cw_rw;
            wr_toggle   <= 1'b0;
            rd_toggle   <= 1'b0;
            cnt_latched <= 1'b0;
            sts_latched <= 1'b0;
            cw_wr       <= 1'b1;
         end else begin
            // A second latch command while one is pending is ignored.
            if (latch_cnt_req && !cnt_latched) begin
               latch_cnt   <= 1'b1;
               cnt_latched <= 1'b1;
            end
            if (latch_sts_req && !sts_latched) begin
               latch_sts   <= 1'b1;
               sts_latched <= 1'b1;
            end
            if (wr_req) begin
               case (rw)
                  RW_LSB: begin
                     cr_wr  <= 1'b1;
                     cr_msb <= 1'b0;
                  end
                  RW_MSB: begin
                     cr_wr  <= 1'b1;
                     cr_msb <= 1'b1;
                  end
                  RW_BOTH: begin
                     cr_wr     <= 1'b1;
                     cr_msb    <= wr_toggle;
                     wr_toggle <= !wr_toggle;
                  end
                  default: ;
               endcase
            end
            if (rd_req) begin
               if (sts_latched) begin
                  sts_latched <= 1'b0;
               end else begin
                  case (rw)
                     RW_LSB, RW_MSB: cnt_latched <= 1'b0;
                     RW_BOTH: begin
                        rd_toggle <= !rd_toggle;
                        if (rd_toggle) cnt_latched <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   always_comb begin
      rd_dat = 8'h00;
      if (sts_latched) begin
         rd_dat = sts;
      end else begin
         case (rw)
            RW_LSB:  rd_dat = ol[7:0];
            RW_MSB:  rd_dat = ol[15:8];
            RW_BOTH: rd_dat = rd_toggle ? ol[15:8] : ol[7:0];
            default: rd_dat = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/pit_bus_controller.sv
// PIT host-bus front end: samples the strobes, detects write/read release edges, decodes to counters.
// Pulses one cycle after the strobe-release edge; read data two cycles after strobes; no backpressure.
module pit_bus_controller
   import pit_pkg::*;
#(
   parameter int NCNT = 3
) (
   input  logic                clk,
   input  logic                rst,
   pit_bus_controller_if.slave bus,
   output logic [NCNT-1:0]     cw_wr,
   output logic [NCNT-1:0]     cr_wr,
   output logic [7:0]          cw_data,
   output logic [7:0]          cr_data,
   output logic                cr_msb,
   output logic [NCNT-1:0]     latch_cnt,
   output logic [NCNT-1:0]     latch_sts,
   input  logic [15:0]         ol0,
   input  logic [15:0]         ol1,
   input  logic [15:0]         ol2,
   input  logic [7:0]          sts0,
   input  logic [7:0]          sts1,
   input  logic [7:0]          sts2
);

   smp_t smp_q;
   smp_t smp_p;
   logic smp_vld;
   logic wr_arm;
   logic rd_arm;
   logic wr_ev;
   logic rd_ev;
   logic rd_sel;

   logic [NCNT-1:0] cw_req;
   logic [NCNT-1:0] lc_req;
   logic [NCNT-1:0] ls_req;
   logic [NCNT-1:0] wr_req;
   logic [NCNT-1:0] rd_req;
   logic [NCNT-1:0] chan_msb;
   logic [7:0]      chan_dat [NCNT];
   logic [15:0]     ol_arr   [NCNT];
   logic [7:0]      sts_arr  [NCNT];
   logic [7:0]      rd_mux;
   logic [7:0]      d_out_q;
   logic            d_oe_q;

   assign ol_arr[0]  = ol0;
   assign ol_arr[1]  = ol1;
   assign ol_arr[2]  = ol2;
   assign sts_arr[0] = sts0;
   assign sts_arr[1] = sts1;
   assign sts_arr[2] = sts2;

   // A strobe must be seen high after reset before its release can count as an event,
   // so a transaction cut by reset cannot complete afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_q   <= SMP_IDLE;
         smp_p   <= SMP_IDLE;
         smp_vld <= 1'b0;
         wr_arm  <= 1'b0;
         rd_arm  <= 1'b0;
      end else begin
         smp_q   <= '{cs: bus.CS, rd: bus.RD, wr: bus.WR, a: bus.A, d: bus.D_in};
         smp_p   <= smp_q;
         smp_vld <= 1'b1;
         wr_arm  <= wr_arm | (smp_vld & smp_q.wr);
         rd_arm  <= rd_arm | (smp_vld & smp_q.rd);
      end
   end

   assign wr_ev  = wr_arm && !smp_p.cs && !smp_p.wr && smp_p.rd && smp_q.wr;
   assign rd_ev  = rd_arm && !smp_p.cs && !smp_p.rd && smp_p.wr && smp_q.rd;
   assign rd_sel = !smp_q.cs && !smp_q.rd && smp_q.wr && (smp_q.a != CW_ADDR);

   always_comb begin
      cw_req = '0;
      lc_req = '0;
      ls_req = '0;
      wr_req = '0;
      rd_req = '0;
      if (wr_ev) begin
         if (smp_p.a == CW_ADDR) begin
            if (smp_p.d[7:6] == SC_READBACK) begin
               for (int i = 0; i < NCNT; i++) begin
                  if (smp_p.d[i+1]) begin
                     lc_req[i] = !smp_p.d[5];
                     ls_req[i] = !smp_p.d[4];
                  end
               end
            end else if (smp_p.d[5:4] != RW_LATCH) begin
               cw_req[smp_p.d[7:6]] = 1'b1;
            end else begin
               lc_req[smp_p.d[7:6]] = 1'b1;
            end
         end else begin
            wr_req[smp_p.a] = 1'b1;
         end
      end
      if (rd_ev && (smp_p.a != CW_ADDR)) rd_req[smp_p.a] = 1'b1;
   end

   for (genvar i = 0; i < NCNT; i++) begin : g_chan
      pit_chan_seq u_chan (
         .clk           (clk),
         .rst           (rst),
         .cw_req        (cw_req[i]),
         .cw_rw         (rw_t'(smp_p.d[5:4])),
         .latch_cnt_req (lc_req[i]),
         .latch_sts_req (ls_req[i]),
         .wr_req        (wr_req[i]),
         .rd_req        (rd_req[i]),
         .ol            (ol_arr[i]),
         .sts           (sts_arr[i]),
         .cw_wr         (cw_wr[i]),
         .cr_wr         (cr_wr[i]),
         .cr_msb        (chan_msb[i]),
         .latch_cnt     (latch_cnt[i]),
         .latch_sts     (latch_sts[i]),
         .rd_dat        (chan_dat[i])
      );
   end

   assign cr_msb = |chan_msb;

   always_comb begin
      rd_mux = 8'h00;
      case (smp_q.a)
         2'd0:    rd_mux = chan_dat[0];
         2'd1:    rd_mux = chan_dat[1];
         2'd2:    rd_mux = chan_dat[2];
         default: rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cw_data <= 8'h00;
         cr_data <= 8'h00;
         d_out_q <= 8'h00;
         d_oe_q  <= 1'b0;
      end else begin
         if (wr_ev) begin
            if (smp_p.a == CW_ADDR) cw_data <= smp_p.d;
            else                    cr_data <= smp_p.d;
         end
         d_oe_q  <= rd_sel;
         d_out_q <= rd_sel ? rd_mux : 8'h00;
      end
   end

   assign bus.D_out = d_out_q;
   assign bus.D_oe  = d_oe_q;

endmodule

// File: doc/pit_bus_controller.md
PIT_BUS_CONTROLLER -- requirements
Module: pit_bus_controller

Interface
REQ-001 Parameter NCNT, default 3, number of counters served; only 3 SHALL be supported.
REQ-002 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 A  in  2  register address: 0-2 counter data, 3 control word.
REQ-005 CS, RD, WR  in  1 each  active-low chip select, read strobe and write strobe.
REQ-006 D_in  in  8  write data bus; D_out  out  8  read data; D_oe  out  1  read-data drive enable.
REQ-007 cw_wr  out  3  one-cycle pulse per counter: load control word cw_data.
REQ-008 cr_wr  out  3  one-cycle pulse per counter: write cr_data into the count register byte selected by cr_msb.
REQ-009 cw_data, cr_data  out  8 each; cr_msb  out  1  (0 = LSB, 1 = MSB).
REQ-010 latch_cnt, latch_sts  out  3 each  one-cycle pulses: freeze output latch, or freeze status byte, of counter i.
REQ-011 ol0..ol2  in  16  output-latch value per counter; sts0..sts2  in  8  status byte per counter.

Function
REQ-012 CS, RD, WR, A and D_in SHALL be registered every cycle. A write event is WR low-to-high with CS low in the same sampled cycle; a read event is RD low-to-high with CS low. All output pulses SHALL occur exactly one cycle after the event.
REQ-013 Sampled RD and WR both low SHALL generate neither event, and D_oe SHALL be 0 during that time.
REQ-014 Each counter SHALL hold: rw[1:0] (00 = unprogrammed), wr_toggle, rd_toggle, cnt_latched, sts_latched.
REQ-015 A control write with SC = D[7:6] < 3 and RW = D[5:4] != 00 SHALL pulse cw_wr[SC], set rw = RW, clear both toggles, and clear both latched flags.
REQ-016 A control write with RW = 00 (counter latch) SHALL pulse latch_cnt[SC] and set cnt_latched, only if cnt_latched is clear; if it is already set, the write SHALL be ignored.
REQ-017 A control write with SC = 3 (read-back) SHALL act on every counter i with D[i+1] = 1:
- D[5] = 0: latch count as in REQ-016.
- D[4] = 0: pulse latch_sts[i] and set sts_latched, only if sts_latched is clear.
REQ-018 A data write to counter i SHALL be handled by rw:
- 01: cr_wr with cr_msb = 0.
- 10: cr_wr with cr_msb = 1.
- 11: cr_msb = wr_toggle, then wr_toggle inverts.
- 00: write ignored, no pulse.
REQ-019 While CS and RD are low and A < 3, D_oe SHALL be 1 and D_out SHALL select, in priority order:
- sts_latched: sts_i.
- otherwise ol_i LSB or MSB according to rw, with rd_toggle selecting the byte in mode 11.
REQ-020 A read event on counter i SHALL advance state:
- If sts_latched: clear it, leave rd_toggle unchanged.
- Otherwise: in mode 11, invert rd_toggle.
- cnt_latched SHALL clear after the final byte (mode 01/10: first byte; mode 11: MSB).
REQ-021 A read at A = 3 SHALL give D_oe = 0 and change no state; a read from an unprogrammed counter SHALL return 8'h00.
REQ-022 Events are edge-defined, so a strobe held low indefinitely SHALL produce exactly one event.

Reset
REQ-023 On rst, all of the following SHALL be 0 immediately and asynchronously: all pulses, D_out, D_oe, every rw, every toggle, every latched flag, and all sampled strobes (sampled strobes reset to the inactive level 1).
REQ-024 A transaction interrupted by rst SHALL be discarded; after release, the first event requires a fresh strobe edge.

Structure
REQ-025 Package pit_pkg SHALL hold:
- rw encodings RW_LATCH, RW_LSB, RW_MSB, RW_BOTH;
- CW_ADDR = 2'd3;
- SC_READBACK = 2'd3.
REQ-026 Per-counter state (REQ-014 to REQ-020) SHALL live in sub-module pit_chan_seq, instantiated NCNT times; address decode and the strobe sampler stay in the top.

Verification
REQ-027 CW 8'h34 then data 8'h10, 8'h27 to A = 0 -> cw_wr[0] pulse, then cr_wr[0] with cr_msb 0 / 8'h10, then cr_msb 1 / 8'h27.
REQ-028 CW 8'h00 twice, ol0 = 16'h1234 -> one latch_cnt[0] pulse only; reads return 8'h34 then 8'h12; cnt_latched clears after the second read.
REQ-029 Read-back 8'hC2 with sts0 = 8'hB4 -> latch_sts[0] and latch_cnt[0] pulse; reads return 8'hB4, then the LSB, then the MSB.
REQ-030 Data write to counter 2 after reset -> no cr_wr pulse; a read from counter 2 returns 8'h00.
REQ-031 Mode-11 counter: LSB write, then CW 8'h74 to counter 1, then write 8'hAA -> cr_msb = 0 (toggle reset).
REQ-032 rst asserted while WR is low, WR released after rst deasserts -> no write event.
